// File: rtl/lcd_hex_writer.sv
// lcd_hex_writer
//   Drives an HD44780-compatible character LCD over its 8-bit write-only bus.
//   After reset it waits T_POWERUP cycles, sends the init commands
//   38/0C/01/06, then shows a 32-bit word as 8 upper-case hex characters on
//   line 1 whenever Update is pulsed. All bus timing is in clock cycles.
//
// Ports
//   CLK       in   system clock, rising edge
//   RST       in   synchronous active-high reset
//   Value     in   32-bit word to display, sampled on an accepted Update
//   Update    in   single-cycle refresh request
//   Busy      out  high during power-up, init or a refresh
//   LCD_RS    out  0 = command, 1 = character data
//   LCD_RW    out  tied to 0
//   LCD_E     out  enable strobe
//   LCD_DATA  out  command / character byte
module lcd_hex_writer #(
   parameter int T_POWERUP = 2000000,
   parameter int T_SETUP   = 2,
   parameter int T_PULSE   = 12,
   parameter int T_WAIT    = 2500,
   parameter int T_CLEAR   = 82000
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [31:0] Value,
   input  logic        Update,
   output logic        Busy,
   output logic        LCD_RS,
   output logic        LCD_RW,
   output logic        LCD_E,
   output logic [7:0]  LCD_DATA
);

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

   // One shared counter serves every timed phase, so it is sized for the
   // longest of them.
   localparam int T_MAX = max2(max2(max2(T_POWERUP, T_SETUP), max2(T_PULSE, T_WAIT)), T_CLEAR);
   localparam int CW    = $clog2(T_MAX + 1);

   localparam logic [CW-1:0] POWERUP_LAST = CW'(T_POWERUP - 1);
   localparam logic [CW-1:0] SETUP_LAST   = CW'(T_SETUP - 1);
   localparam logic [CW-1:0] PULSE_LAST   = CW'(T_PULSE - 1);
   localparam logic [CW-1:0] WAIT_LAST    = CW'(T_WAIT - 1);
   localparam logic [CW-1:0] CLEAR_LAST   = CW'(T_CLEAR - 1);

   localparam logic [7:0] CMD_CLEAR = 8'h01;
   localparam logic [7:0] CMD_HOME  = 8'h80;

   typedef enum logic [1:0] {
      ST_PWRUP,
      ST_INIT,
      ST_IDLE,
      ST_SEND
   } state_t;

   typedef enum logic [1:0] {
      PH_SETUP,
      PH_PULSE,
      PH_WAIT
   } phase_t;

   state_t        state_reg;
   phase_t        phase_reg;
   logic [CW-1:0] cnt_reg;
   logic [3:0]    idx_reg;
   logic [31:0]   value_reg;
   logic [31:0]   pending_value_reg;
   logic          pending_reg;
   logic          busy_reg;
   logic          rs_reg;
   logic          e_reg;
   logic [7:0]    data_reg;

   logic [CW-1:0] wait_last;
   logic          last_byte;

   function automatic logic [7:0] init_cmd(input logic [3:0] i);
      case (i)
         4'd1:    return 8'h0C;
         4'd2:    return 8'h01;
         4'd3:    return 8'h06;
         default: return 8'h38;
      endcase
   endfunction

   // Nibble i of the word, counted from the most-significant end.
   function automatic logic [3:0] nibble_sel(input logic [31:0] v, input logic [3:0] i);
      case (i)
         4'd0:    return v[31:28];
         4'd1:    return v[27:24];
         4'd2:    return v[23:20];
         4'd3:    return v[19:16];
         4'd4:    return v[15:12];
         4'd5:    return v[11:8];
         4'd6:    return v[7:4];
         default: return v[3:0];
      endcase
   endfunction

   // 0-9 -> '0'..'9', A-F -> 'A'..'F' ('A' = 8'h37 + 10).
   function automatic logic [7:0] hex_char(input logic [3:0] n);
      if (n < 4'd10)
         return 8'h30 + {4'h0, n};
      else
         return 8'h37 + {4'h0, n};
   endfunction

   // Only the clear-display command needs the long settle time.
   assign wait_last = (!rs_reg && data_reg == CMD_CLEAR) ? CLEAR_LAST : WAIT_LAST;
   assign last_byte = (state_reg == ST_INIT) ? (idx_reg == 4'd3) : (idx_reg == 4'd8);

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg         <= ST_PWRUP;
         phase_reg         <= PH_SETUP;
         cnt_reg           <= '0;
         idx_reg           <= '0;
         value_reg         <= '0;
         pending_value_reg <= '0;
         pending_reg       <= 1'b0;
         busy_reg          <= 1'b1;
         rs_reg            <= 1'b0;
         e_reg             <= 1'b0;
         data_reg          <= 8'h00;
      end else begin
         // Requests arriving while busy are parked; the newest one wins.
         // The end-of-transfer branch below overrides this when it consumes
         // the request directly.
         if (Update && busy_reg) begin
            pending_reg       <= 1'b1;
            pending_value_reg <= Value;
         end

         case (state_reg)
            ST_PWRUP: begin
               if (cnt_reg == POWERUP_LAST) begin
                  state_reg <= ST_INIT;
                  phase_reg <= PH_SETUP;
                  cnt_reg   <= '0;
                  idx_reg   <= '0;
                  rs_reg    <= 1'b0;
                  data_reg  <= init_cmd(4'd0);
               end else begin
                  cnt_reg <= cnt_reg + 1'b1;
               end
            end

            ST_IDLE: begin
               if (Update) begin
                  value_reg <= Value;
                  state_reg <= ST_SEND;
                  phase_reg <= PH_SETUP;
                  cnt_reg   <= '0;
                  idx_reg   <= '0;
                  rs_reg    <= 1'b0;
                  data_reg  <= CMD_HOME;
                  busy_reg  <= 1'b1;
               end
            end

            default: begin
               // ST_INIT and ST_SEND share the byte-transfer sequencer.
               case (phase_reg)
                  PH_SETUP: begin
                     if (cnt_reg == SETUP_LAST) begin
                        phase_reg <= PH_PULSE;
                        cnt_reg   <= '0;
                        e_reg     <= 1'b1;
                     end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                     end
                  end

                  PH_PULSE: begin
                     if (cnt_reg == PULSE_LAST) begin
                        phase_reg <= PH_WAIT;
                        cnt_reg   <= '0;
                        e_reg     <= 1'b0;
                     end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                     end
                  end

                  default: begin
                     if (cnt_reg == wait_last) begin
                        cnt_reg <= '0;
                        if (!last_byte) begin
                           idx_reg   <= idx_reg + 4'd1;
                           phase_reg <= PH_SETUP;
                           if (state_reg == ST_INIT) begin
                              rs_reg   <= 1'b0;
                              data_reg <= init_cmd(idx_reg + 4'd1);
                           end else begin
                              rs_reg   <= 1'b1;
                              data_reg <= hex_char(nibble_sel(value_reg, idx_reg));
                           end
                        end else if (Update || pending_reg) begin
                           // Chain straight into a refresh; Busy stays high.
                           // A request on this very cycle is newer than the
                           // parked one.
                           value_reg   <= Update ? Value : pending_value_reg;
                           pending_reg <= 1'b0;
                           state_reg   <= ST_SEND;
                           phase_reg   <= PH_SETUP;
                           idx_reg     <= '0;
                           rs_reg      <= 1'b0;
                           data_reg    <= CMD_HOME;
                        end else begin
                           state_reg <= ST_IDLE;
                           busy_reg  <= 1'b0;
                        end
                     end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                     end
                  end
               endcase
            end
         endcase
      end
   end

   assign Busy     = busy_reg;
   assign LCD_RS   = rs_reg;
   assign LCD_RW   = 1'b0;
   assign LCD_E    = e_reg;
   assign LCD_DATA = data_reg;

endmodule

// File: doc/lcd_hex_writer.md
# lcd_hex_writer

Character-LCD driver that sits downstream of the display-select mux on the board: it takes the 32-bit word chosen for display and writes it as 8 upper-case hex characters to an HD44780-compatible module. The interface is 8-bit and write-only. The block runs the controller power-up/init sequence itself, then refreshes line 1 whenever the core requests an update. All LCD bus timing comes from cycle-count parameters, so the block is clock-frequency agnostic.

## Interface
- T_POWERUP, 2000000: cycles of wait after reset before the first command (40 ms at 50 MHz).
- T_SETUP, 2: cycles RS/DATA are held stable with E low before the E rising edge.
- T_PULSE, 12: cycles E is held high.
- T_WAIT, 2500: cycles after E falls before the next byte may start (50 µs).
- T_CLEAR, 82000: replaces T_WAIT after the clear-display command (1.64 ms).
- CLK  in  1  system clock; all logic on the rising edge.
- RST  in  1  synchronous, active-high reset.
- Value  in  32  word to display; sampled only on an accepted Update.
- Update  in  1  single-cycle request to show Value.
- Busy  out  1  high during init or an in-progress refresh.
- LCD_RS  out  1  0 = command, 1 = character data.
- LCD_RW  out  1  constant 0 (write-only).
- LCD_E  out  1  enable strobe.
- LCD_DATA  out  8  command or character byte.

## Operation
- Reset values: LCD_E=0, LCD_RS=0, LCD_RW=0, LCD_DATA=8'h00, Busy=1, pending flag=0, latched value=0.
- States:
  - PWRUP: count T_POWERUP, then go to INIT.
  - INIT: send the commands 8'h38, 8'h0C, 8'h01, 8'h06 in that order, then go to IDLE.
  - IDLE: Busy=0.
  - SEND: send 9 bytes, then go to IDLE.
- Byte transfer has three phases, with all outputs registered:
  - SETUP: RS and DATA driven, E=0, for T_SETUP cycles.
  - PULSE: E=1 for T_PULSE cycles; RS and DATA unchanged.
  - WAIT: E=0 for T_WAIT cycles, or T_CLEAR when the byte is the 8'h01 command.
- RS and DATA stay stable through WAIT and change only when the next SETUP begins.
- SEND byte 0 is the command 8'h80 (DDRAM address 0) with RS=0.
- SEND bytes 1..8 carry RS=1 and the ASCII hex digits of the latched value, most-significant nibble first.
  - Nibble 0–9 maps to 8'h30+n.
  - Nibble A–F maps to 8'h41+(n−10).
- Update in IDLE: Value is latched and SEND starts on the next cycle.
- Update while Busy (including during INIT): Value is stored in a pending register and the pending flag is set.
  - A later Update overwrites the pending register; the latest value wins and there is no queue.
- On leaving SEND or INIT with pending=1, the block goes straight to SEND with the pending value and clears the flag. Busy does not drop in between.
- Update arriving on the same cycle the block returns to IDLE is treated as an IDLE accept; the new Value is used.
- RST asserted at any point aborts the transfer, drives E low on the next edge, and restarts from PWRUP. The pending request is discarded.

## Timing
- Per byte: T_SETUP + T_PULSE + T_WAIT cycles (T_CLEAR in place of T_WAIT for 8'h01).
- Update accepted at edge t (IDLE):
  - Busy=1, RS=0, DATA=8'h80 from t+1.
  - First E rise at t+1+T_SETUP.
- A full refresh takes 9·(T_SETUP+T_PULSE+T_WAIT) cycles. Busy falls on the cycle after the last WAIT ends, if nothing is pending.
- Init is complete T_POWERUP + 3·(T_SETUP+T_PULSE+T_WAIT) + (T_SETUP+T_PULSE+T_CLEAR) cycles after RST deasserts. No E pulse occurs before then.
- Counters must be wide enough for the largest parameter. The width is derived with $clog2, with no wrap.

## Test plan
Bench parameters: T_POWERUP=10, T_SETUP=1, T_PULSE=2, T_WAIT=3, T_CLEAR=8.
- Reset → E=0 and Busy=1 held through init. Exactly 4 E pulses occur, with DATA 38, 0C, 01, 06 and RS=0. The gap after 01 is 8 cycles. Busy falls at cycle 10+3·6+11=39.
- Update with Value=32'h1234ABCF in IDLE → 9 E pulses: 80 (RS=0), then 31 32 33 34 41 42 43 46 (RS=1). Period is 6 cycles; Busy is high for 54 cycles.
- Value=32'h00000000 then 32'hFFFFFFFF → characters are all 8'h30, then all 8'h46.
- Update with 32'hAAAA0000 mid-refresh, then 32'h55550000 two cycles later → the current refresh completes unchanged. The next refresh follows with no Busy gap and shows "55550000" only.
- Update pulsed during init → the first SEND starts immediately after the 06 command's WAIT.
- RST asserted during a PULSE → E=0 on the next edge and no further pulses for T_POWERUP cycles. The init sequence repeats and no refresh follows.
